// File: rtl/fp_pkg.sv
// Shared floating-point definitions: rounding modes, operand classes, flag layout.
// Used by the multiplier pipeline and by the reusable rounding/pack stage.
package fp_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rm_e;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'b00,
    CLS_INF  = 2'b01,
    CLS_NAN  = 2'b10,
    CLS_NORM = 2'b11
  } cls_e;

  // Flag vector layout, MSB first: {invalid, overflow, underflow, inexact, zero}
  localparam int unsigned FLAG_W         = 5;
  localparam int unsigned FLAG_INVALID   = 4;
  localparam int unsigned FLAG_OVERFLOW  = 3;
  localparam int unsigned FLAG_UNDERFLOW = 2;
  localparam int unsigned FLAG_INEXACT   = 1;
  localparam int unsigned FLAG_ZERO      = 0;

  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// Issue/result handshake bundle of the pipelined FP multiplier.
// slave = the multiplier, master = issue logic / writeback side.
interface fp_mul_pipe_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned TAG_W = 4
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [1:0]       R_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     z;
  logic [TAG_W-1:0] out_tag;
  logic             invalid_flag;
  logic             overflow_flag;
  logic             underflow_flag;
  logic             inexact_flag;
  logic             zero_flag;

  modport slave (
    input  in_valid, a, b, R_mode, in_tag, out_ready,
    output in_ready, out_valid, z, out_tag,
           invalid_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag
  );

  modport master (
    output in_valid, a, b, R_mode, in_tag, out_ready,
    input  in_ready, out_valid, z, out_tag,
           invalid_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag
  );

endinterface

// File: rtl/fp_round.sv
// Combinational round / overflow / underflow / special-case pack stage.
// Takes a normalised significand with guard, round and sticky bits.
module fp_round
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                    i_sign,
  input  logic signed [EXP_W+1:0] i_exp,
  input  logic [MAN_W:0]          i_mant,
  input  logic                    i_guard,
  input  logic                    i_round,
  input  logic                    i_sticky,
  input  rm_e                     i_rm,
  input  cls_e                    i_cls_a,
  input  cls_e                    i_cls_b,
  output logic [EXP_W+MAN_W:0]    o_z,
  output logic [FLAG_W-1:0]       o_flags
);

  localparam int unsigned EW = EXP_W + 2;
  localparam logic signed [EW-1:0] EXP_TOP = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_MIN = EW'(1);

  logic                    w_inexact;
  logic                    w_inc;
  logic [MAN_W+1:0]        w_sum;
  logic                    w_carry;
  logic [MAN_W-1:0]        w_frac;
  logic signed [EW-1:0]    w_exp_r;
  logic                    w_ovf;
  logic                    w_unf;
  logic                    w_nan;
  logic                    w_inf;
  logic                    w_zero;
  logic [EXP_W+MAN_W:0]    w_inf_z;
  logic [EXP_W+MAN_W:0]    w_max_z;
  logic [EXP_W+MAN_W:0]    w_ovf_z;

  assign w_inexact = i_guard | i_round | i_sticky;

  always_comb begin
    w_inc = 1'b0;
    unique case (i_rm)
      RM_RNE:  w_inc = i_guard & (i_round | i_sticky | i_mant[0]);
      RM_RTZ:  w_inc = 1'b0;
      RM_RUP:  w_inc = ~i_sign & w_inexact;
      RM_RDN:  w_inc = i_sign & w_inexact;
      default: w_inc = 1'b0;
    endcase
  end

  // A carry out of the significand leaves 1.000..0, so the shifted fraction is all zero.
  assign w_sum   = {1'b0, i_mant} + {{(MAN_W + 1){1'b0}}, w_inc};
  assign w_carry = w_sum[MAN_W+1];
  assign w_frac  = w_carry ? w_sum[MAN_W:1] : w_sum[MAN_W-1:0];
  assign w_exp_r = i_exp + EW'(w_carry);
  assign w_ovf   = (w_exp_r >= EXP_TOP);
  assign w_unf   = (w_exp_r < EXP_MIN);

  assign w_nan  = (i_cls_a == CLS_NAN) | (i_cls_b == CLS_NAN) |
                  ((i_cls_a == CLS_INF) & (i_cls_b == CLS_ZERO)) |
                  ((i_cls_a == CLS_ZERO) & (i_cls_b == CLS_INF));
  assign w_inf  = (i_cls_a == CLS_INF) | (i_cls_b == CLS_INF);
  assign w_zero = (i_cls_a == CLS_ZERO) | (i_cls_b == CLS_ZERO);

  assign w_inf_z = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign w_max_z = {i_sign, {(EXP_W - 1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

  always_comb begin
    w_ovf_z = w_inf_z;
    unique case (i_rm)
      RM_RNE:  w_ovf_z = w_inf_z;
      RM_RTZ:  w_ovf_z = w_max_z;
      RM_RUP:  w_ovf_z = i_sign ? w_max_z : w_inf_z;
      RM_RDN:  w_ovf_z = i_sign ? w_inf_z : w_max_z;
      default: w_ovf_z = w_inf_z;
    endcase
  end

  always_comb begin
    o_z     = '0;
    o_flags = '0;
    if (w_nan) begin
      o_z                   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
      o_flags[FLAG_INVALID] = 1'b1;
    end else if (w_inf) begin
      o_z = w_inf_z;
    end else if (w_zero) begin
      o_z                = {i_sign, {(EXP_W + MAN_W){1'b0}}};
      o_flags[FLAG_ZERO] = 1'b1;
    end else if (w_ovf) begin
      o_z                    = w_ovf_z;
      o_flags[FLAG_OVERFLOW] = 1'b1;
      o_flags[FLAG_INEXACT]  = 1'b1;
    end else if (w_unf) begin
      o_z                     = {i_sign, {(EXP_W + MAN_W){1'b0}}};
      o_flags[FLAG_UNDERFLOW] = 1'b1;
      o_flags[FLAG_INEXACT]   = 1'b1;
      o_flags[FLAG_ZERO]      = 1'b1;
    end else begin
      o_z                   = {i_sign, w_exp_r[EXP_W-1:0], w_frac};
      o_flags[FLAG_INEXACT] = w_inexact;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Four-stage pipelined IEEE-754 multiplier with tag passthrough and exception flags.
// A single global stall freezes every stage while the result is not accepted.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned TAG_W = 4
) (
  input logic          CLK,
  input logic          RST,
  fp_mul_pipe_if.slave bus
);

  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned EW = EXP_W + 2;
  localparam int unsigned PW = 2 * MAN_W + 2;
  localparam logic [EW-1:0] BIAS = EW'(fp_bias(EXP_W));

  // Exponent 0 covers subnormals too: they are flushed to zero.
  function automatic cls_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0) return CLS_ZERO;
    if (e == '1) return (f == '0) ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

  logic                    w_stall;
  logic [EXP_W-1:0]        w_exp_a;
  logic [EXP_W-1:0]        w_exp_b;
  logic [EW-1:0]           w_exp_sum;

  logic                    r1_valid, r2_valid, r3_valid, r4_valid;
  logic [TAG_W-1:0]        r1_tag, r2_tag, r3_tag, r4_tag;
  rm_e                     r1_rm, r2_rm, r3_rm;
  cls_e                    r1_cls_a, r1_cls_b, r2_cls_a, r2_cls_b, r3_cls_a, r3_cls_b;
  logic                    r1_sign, r2_sign, r3_sign;
  logic signed [EW-1:0]    r1_exp, r2_exp, r3_exp;
  logic [MAN_W:0]          r1_sig_a, r1_sig_b;
  logic [PW-1:0]           r2_prod;
  logic [MAN_W:0]          r3_mant;
  logic                    r3_guard, r3_round, r3_sticky;
  logic [W-1:0]            r4_z;
  logic [FLAG_W-1:0]       r4_flags;

  logic                    w_norm_hi;
  logic [MAN_W:0]          w_mant;
  logic                    w_guard, w_round, w_sticky;
  logic signed [EW-1:0]    w_exp_n;
  logic [W-1:0]            w_z;
  logic [FLAG_W-1:0]       w_flags;

  assign w_stall      = r4_valid & ~bus.out_ready;
  assign bus.in_ready = ~w_stall;

  assign w_exp_a   = bus.a[W-2 -: EXP_W];
  assign w_exp_b   = bus.b[W-2 -: EXP_W];
  assign w_exp_sum = {2'b00, w_exp_a} + {2'b00, w_exp_b} - BIAS;

  // Product of two [1,2) significands lies in [1,4): MSB set means shift right by one.
  assign w_norm_hi = r2_prod[PW-1];
  assign w_mant    = w_norm_hi ? r2_prod[PW-1 -: MAN_W+1] : r2_prod[PW-2 -: MAN_W+1];
  assign w_guard   = w_norm_hi ? r2_prod[MAN_W]   : r2_prod[MAN_W-1];
  assign w_round   = w_norm_hi ? r2_prod[MAN_W-1] : r2_prod[MAN_W-2];
  assign w_sticky  = w_norm_hi ? |r2_prod[MAN_W-2:0] : |r2_prod[MAN_W-3:0];
  assign w_exp_n   = r2_exp + EW'(w_norm_hi);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r1_valid  <= 1'b0;
      r1_tag    <= '0;
      r1_rm     <= RM_RNE;
      r1_cls_a  <= CLS_ZERO;
      r1_cls_b  <= CLS_ZERO;
      r1_sign   <= 1'b0;
      r1_exp    <= '0;
      r1_sig_a  <= '0;
      r1_sig_b  <= '0;
      r2_valid  <= 1'b0;
      r2_tag    <= '0;
      r2_rm     <= RM_RNE;
      r2_cls_a  <= CLS_ZERO;
      r2_cls_b  <= CLS_ZERO;
      r2_sign   <= 1'b0;
      r2_exp    <= '0;
      r2_prod   <= '0;
      r3_valid  <= 1'b0;
      r3_tag    <= '0;
      r3_rm     <= RM_RNE;
      r3_cls_a  <= CLS_ZERO;
      r3_cls_b  <= CLS_ZERO;
      r3_sign   <= 1'b0;
      r3_exp    <= '0;
      r3_mant   <= '0;
      r3_guard  <= 1'b0;
      r3_round  <= 1'b0;
      r3_sticky <= 1'b0;
    end else if (!w_stall) begin
      r1_valid  <= bus.in_valid;
      r1_tag    <= bus.in_tag;
      r1_rm     <= rm_e'(bus.R_mode);
      r1_cls_a  <= classify(w_exp_a, bus.a[MAN_W-1:0]);
      r1_cls_b  <= classify(w_exp_b, bus.b[MAN_W-1:0]);
      r1_sign   <= bus.a[W-1] ^ bus.b[W-1];
      r1_exp    <= w_exp_sum;
      r1_sig_a  <= {1'b1, bus.a[MAN_W-1:0]};
      r1_sig_b  <= {1'b1, bus.b[MAN_W-1:0]};
      r2_valid  <= r1_valid;
      r2_tag    <= r1_tag;
      r2_rm     <= r1_rm;
      r2_cls_a  <= r1_cls_a;
      r2_cls_b  <= r1_cls_b;
      r2_sign   <= r1_sign;
      r2_exp    <= r1_exp;
      r2_prod   <= PW'(r1_sig_a) * PW'(r1_sig_b);
      r3_valid  <= r2_valid;
      r3_tag    <= r2_tag;
      r3_rm     <= r2_rm;
      r3_cls_a  <= r2_cls_a;
      r3_cls_b  <= r2_cls_b;
      r3_sign   <= r2_sign;
      r3_exp    <= w_exp_n;
      r3_mant   <= w_mant;
      r3_guard  <= w_guard;
      r3_round  <= w_round;
      r3_sticky <= w_sticky;
    end
  end

  fp_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .i_sign   (r3_sign),
    .i_exp    (r3_exp),
    .i_mant   (r3_mant),
    .i_guard  (r3_guard),
    .i_round  (r3_round),
    .i_sticky (r3_sticky),
    .i_rm     (r3_rm),
    .i_cls_a  (r3_cls_a),
    .i_cls_b  (r3_cls_b),
    .o_z      (w_z),
    .o_flags  (w_flags)
  );

  // Output payload only changes when a real result arrives, so bubbles never disturb it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r4_valid <= 1'b0;
      r4_tag   <= '0;
      r4_z     <= '0;
      r4_flags <= '0;
    end else if (!w_stall) begin
      r4_valid <= r3_valid;
      if (r3_valid) begin
        r4_tag   <= r3_tag;
        r4_z     <= w_z;
        r4_flags <= w_flags;
      end
    end
  end

  assign bus.out_valid      = r4_valid;
  assign bus.out_tag        = r4_tag;
  assign bus.z              = r4_z;
  assign bus.invalid_flag   = r4_flags[FLAG_INVALID];
  assign bus.overflow_flag  = r4_flags[FLAG_OVERFLOW];
  assign bus.underflow_flag = r4_flags[FLAG_UNDERFLOW];
  assign bus.inexact_flag   = r4_flags[FLAG_INEXACT];
  assign bus.zero_flag      = r4_flags[FLAG_ZERO];

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: directed vector table, backpressure and reset sequences,
// half-precision sanity case and randomized traffic against an arithmetic reference model.
module tb_fp_mul_pipe;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  fp_mul_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) bus32 ();
  fp_mul_pipe_if #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) bus16 ();

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus32)
  );

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) u_dut16 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus16)
  );

  logic [4:0] fl32, fl16;
  assign fl32 = {bus32.invalid_flag, bus32.overflow_flag, bus32.underflow_flag,
                 bus32.inexact_flag, bus32.zero_flag};
  assign fl16 = {bus16.invalid_flag, bus16.overflow_flag, bus16.underflow_flag,
                 bus16.inexact_flag, bus16.zero_flag};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
  endtask

  // Reference: exact integer product, then keep 24 significant bits and round the
  // discarded remainder by comparing it against half an ulp. Returns {flags, z}.
  function automatic logic [36:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] rm);
    logic s, inexact, up, to_inf;
    int ea, eb, e, msb, drop;
    longint unsigned p, q, rem, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
        (ea == 255 && eb == 0) || (ea == 0 && eb == 255))
      return {5'b10000, 32'h7FC00000};
    if (ea == 255 || eb == 255) return {5'b00000, s, 8'hFF, 23'h0};
    if (ea == 0 || eb == 0) return {5'b00001, s, 31'h0};
    p   = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
    msb = 0;
    for (int i = 0; i < 64; i++) if (p[i]) msb = i;
    drop    = msb - 23;
    q       = p >> drop;
    rem     = p - (q << drop);
    half    = 64'd1 << (drop - 1);
    e       = ea + eb - 127 + (msb - 46);
    inexact = (rem != 0);
    case (rm)
      2'd0:    up = (rem > half) || (rem == half && q[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = !s && inexact;
      default: up = s && inexact;
    endcase
    q = q + 64'(up);
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) begin
      to_inf = (rm == 2'd0) || (rm == 2'd2 && !s) || (rm == 2'd3 && s);
      return {5'b01010, to_inf ? {s, 8'hFF, 23'h0} : {s, 8'hFE, 23'h7FFFFF}};
    end
    if (e < 1) return {5'b00111, s, 31'h0};
    return {3'b000, inexact, 1'b0, s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    int unsigned sel;
    logic [31:0] v;
    sel = $urandom_range(0, 15);
    v   = $urandom;
    if (sel == 0) v[30:23] = 8'hFF;
    else if (sel == 1) v[30:23] = 8'h00;
    else if (sel == 2) begin
      v[30:23] = 8'hFF;
      v[22:0]  = '0;
    end else if (sel != 3) v[30:23] = 8'($urandom_range(60, 195));
    return v;
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  rm;
    logic [31:0] z;
    logic [4:0]  fl;
  } vec_t;

  vec_t vecs[16];

  task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                         input logic [3:0] tag);
    bus32.a        = a;
    bus32.b        = b;
    bus32.R_mode   = rm;
    bus32.in_tag   = tag;
    bus32.in_valid = 1'b1;
  endtask

  // Called #1 after the accept edge; returns the number of rising edges, accept edge
  // included, until out_valid is seen.
  task automatic wait_out32(output int edges);
    edges = 1;
    while (!bus32.out_valid && edges < 12) begin
      @(posedge CLK); #1;
      edges++;
    end
  endtask

  task automatic wait_out16(output int edges);
    edges = 1;
    while (!bus16.out_valid && edges < 12) begin
      @(posedge CLK); #1;
      edges++;
    end
  endtask

  initial begin
    int edges, next, got, sent, cyc;
    logic [31:0] held_z, ra, rb;
    logic [1:0] rrm;
    logic [40:0] exp_q[$];
    logic [40:0] exp_item, prev_out;
    logic prev_stall, accept, saw_valid;
    int n_rand;

    vecs[0]  = '{32'h3FC00000, 32'h40000000, 2'd0, 32'h40400000, 5'b00000};
    vecs[1]  = '{32'h3F800001, 32'h3F800001, 2'd0, 32'h3F800002, 5'b00010};
    vecs[2]  = '{32'h3F800001, 32'h3F800001, 2'd2, 32'h3F800003, 5'b00010};
    vecs[3]  = '{32'h3F800001, 32'h3F800001, 2'd1, 32'h3F800002, 5'b00010};
    vecs[4]  = '{32'h7F800000, 32'h00000000, 2'd0, 32'h7FC00000, 5'b10000};
    vecs[5]  = '{32'hFF800000, 32'h40000000, 2'd0, 32'hFF800000, 5'b00000};
    vecs[6]  = '{32'h7F7FFFFF, 32'h40000000, 2'd0, 32'h7F800000, 5'b01010};
    vecs[7]  = '{32'h7F7FFFFF, 32'h40000000, 2'd1, 32'h7F7FFFFF, 5'b01010};
    vecs[8]  = '{32'hFF7FFFFF, 32'h40000000, 2'd2, 32'hFF7FFFFF, 5'b01010};
    vecs[9]  = '{32'h00800000, 32'h3F000000, 2'd0, 32'h00000000, 5'b00111};
    vecs[10] = '{32'h3F800001, 32'h3FC00000, 2'd0, 32'h3FC00002, 5'b00010};
    vecs[11] = '{32'h3F800003, 32'h3FC00000, 2'd0, 32'h3FC00004, 5'b00010};
    vecs[12] = '{32'h80000000, 32'h40000000, 2'd0, 32'h80000000, 5'b00001};
    vecs[13] = '{32'h7F7FFFFF, 32'h40000000, 2'd3, 32'h7F7FFFFF, 5'b01010};
    vecs[14] = '{32'h7F800001, 32'h3F800000, 2'd0, 32'h7FC00000, 5'b10000};
    vecs[15] = '{32'h00000001, 32'h3F800000, 2'd0, 32'h00000000, 5'b00001};

    RST             = 1'b0;
    bus32.in_valid  = 1'b0;
    bus32.a         = '0;
    bus32.b         = '0;
    bus32.R_mode    = 2'd0;
    bus32.in_tag    = '0;
    bus32.out_ready = 1'b1;
    bus16.in_valid  = 1'b0;
    bus16.a         = '0;
    bus16.b         = '0;
    bus16.R_mode    = 2'd0;
    bus16.in_tag    = '0;
    bus16.out_ready = 1'b1;

    repeat (2) @(posedge CLK);
    #1;
    check("reset_out_valid", 64'(bus32.out_valid), 64'd0);
    check("reset_z", 64'(bus32.z), 64'd0);
    check("reset_tag", 64'(bus32.out_tag), 64'd0);
    check("reset_flags", 64'(fl32), 64'd0);
    check("reset_in_ready", 64'(bus32.in_ready), 64'd1);
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(posedge CLK); #1;
      drive32(vecs[i].a, vecs[i].b, vecs[i].rm, 4'(i));
      @(posedge CLK); #1;
      bus32.in_valid = 1'b0;
      wait_out32(edges);
      check($sformatf("vec%0d_latency", i), 64'(edges), 64'd4);
      check($sformatf("vec%0d_z", i), 64'(bus32.z), 64'(vecs[i].z));
      check($sformatf("vec%0d_flags", i), 64'(fl32), 64'(vecs[i].fl));
      check($sformatf("vec%0d_tag", i), 64'(bus32.out_tag), 64'(i));
    end

    // binary16 instance: 1.5 * 2.0
    @(posedge CLK); #1;
    bus16.a        = 16'h3E00;
    bus16.b        = 16'h4000;
    bus16.in_tag   = 4'h7;
    bus16.in_valid = 1'b1;
    @(posedge CLK); #1;
    bus16.in_valid = 1'b0;
    wait_out16(edges);
    check("h16_latency", 64'(edges), 64'd4);
    check("h16_z", 64'(bus16.z), 64'h4200);
    check("h16_flags", 64'(fl16), 64'd0);
    check("h16_tag", 64'(bus16.out_tag), 64'd7);

    // Backpressure: op k is 2^k * 3, result 3*2^k, tag k.
    @(posedge CLK); #1;
    bus32.out_ready = 1'b0;
    next = 0;
    for (int c = 0; c < 10; c++) begin
      if (next < 6) drive32({1'b0, 8'(127 + next), 23'h0}, 32'h40400000, 2'd0, 4'(next));
      else bus32.in_valid = 1'b0;
      @(negedge CLK);
      if (bus32.in_valid && bus32.in_ready) next++;
      @(posedge CLK); #1;
    end
    check("bp_accepted", 64'(next), 64'd4);
    check("bp_in_ready", 64'(bus32.in_ready), 64'd0);
    check("bp_out_valid", 64'(bus32.out_valid), 64'd1);
    held_z = bus32.z;
    check("bp_head_z", 64'(held_z), 64'h40400000);
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      check("bp_hold_z", 64'(bus32.z), 64'(held_z));
      check("bp_hold_tag", 64'(bus32.out_tag), 64'd0);
    end
    bus32.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (next < 6) drive32({1'b0, 8'(127 + next), 23'h0}, 32'h40400000, 2'd0, 4'(next));
      else bus32.in_valid = 1'b0;
      @(negedge CLK);
      check("bp_drain_valid", 64'(bus32.out_valid), 64'd1);
      check("bp_drain_tag", 64'(bus32.out_tag), 64'(k));
      check("bp_drain_z", 64'(bus32.z), 64'({1'b0, 8'(128 + k), 23'h400000}));
      if (bus32.in_valid && bus32.in_ready) next++;
      @(posedge CLK); #1;
    end
    bus32.in_valid = 1'b0;
    repeat (6) @(posedge CLK);
    #1;

    // Randomized traffic with random backpressure against the reference model.
    n_rand     = 300;
    sent       = 0;
    got        = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    prev_out   = '0;
    while (got < n_rand && cyc < 6000) begin
      if (!bus32.in_valid && sent < n_rand && $urandom_range(0, 3) != 0) begin
        ra  = rand_op();
        rb  = rand_op();
        rrm = 2'($urandom_range(0, 3));
        drive32(ra, rb, rrm, 4'(sent));
      end
      bus32.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge CLK);
      if (prev_stall)
        check("rand_hold", 64'({bus32.out_valid, bus32.out_tag, fl32, bus32.z}),
              64'({1'b1, prev_out}));
      if (bus32.out_valid && bus32.out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_spurious", 64'd1, 64'd0);
        end else begin
          exp_item = exp_q.pop_front();
          check("rand_result", 64'({bus32.out_tag, fl32, bus32.z}), 64'(exp_item));
        end
        got++;
      end
      accept = bus32.in_valid && bus32.in_ready;
      if (accept) begin
        exp_q.push_back({bus32.in_tag, ref_mul(bus32.a, bus32.b, bus32.R_mode)});
        sent++;
      end
      prev_stall = bus32.out_valid && !bus32.out_ready;
      prev_out   = {bus32.out_tag, fl32, bus32.z};
      @(posedge CLK); #1;
      if (accept) bus32.in_valid = 1'b0;
      cyc++;
    end
    check("rand_all_received", 64'(got), 64'(n_rand));
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b1;
    repeat (6) @(posedge CLK);
    #1;

    // Asynchronous reset with three operations in flight.
    for (int k = 0; k < 3; k++) begin
      drive32(32'h3FC00000, 32'h40000000, 2'd0, 4'(8 + k));
      @(posedge CLK); #1;
    end
    bus32.in_valid = 1'b0;
    @(posedge CLK); #1;
    check("rst_pre_valid", 64'(bus32.out_valid), 64'd1);
    #2;
    RST = 1'b0;
    #1;
    check("rst_async_valid", 64'(bus32.out_valid), 64'd0);
    check("rst_async_z", 64'(bus32.z), 64'd0);
    check("rst_async_tag", 64'(bus32.out_tag), 64'd0);
    check("rst_async_flags", 64'(fl32), 64'd0);
    check("rst_async_in_ready", 64'(bus32.in_ready), 64'd1);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST       = 1'b1;
    saw_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      saw_valid = saw_valid | bus32.out_valid;
    end
    check("rst_no_stale", 64'(saw_valid), 64'd0);
    check("rst_in_ready", 64'(bus32.in_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
